// File: rtl/clb4_seq_adder.sv
// ============================================================================
// clb4_seq_adder
// ----------------------------------------------------------------------------
// Multi-cycle WIDTH-bit adder built around a single 4-bit carry-lookahead
// slice (clb4). One nibble is processed per clock, LSB nibble first, with the
// nibble carry held in a register between cycles. This is the low-area
// companion to the combinational cla32 path. Use it in blocks that can wait
// NIB cycles for a result.
//
// Handshake: start / busy / done.
//   - start is sampled only in IDLE or DONE. The accepting edge captures
//     a, b and ci, so these inputs may change freely after that edge.
//   - busy is high for exactly NIB cycles while the nibbles are processed.
//   - done is a one-cycle pulse. On that cycle s/co first become valid.
//   - s/co hold their values until the first nibble write of the next
//     operation.
//   - A start during the DONE cycle is accepted directly, so back-to-back
//     operations have no idle bubble.
//
// Parameters:
//   WIDTH    operand width in bits. It must be a multiple of 4 and >= 8.
//            NIB = WIDTH/4.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   start    in   request an addition
//   a, b     in   WIDTH-bit operands
//   ci       in   carry-in
//   busy     out  high while nibbles are being processed
//   done     out  one-cycle pulse when s/co become valid
//   s        out  registered WIDTH-bit sum
//   co       out  registered carry-out of the MSB nibble
//
// Optional feature (macro CLB4_SEQ_SUB_EN):
//   sub      in   captured with the operands. When 1, the adder computes
//                 a - b as a + ~b + 1. In that mode co=1 means no borrow.
//   ovf      out  registered signed overflow of the MSB nibble. It is the
//                 carry into the MSB XOR the carry out of the MSB.
// ============================================================================
module clb4_seq_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
`ifdef CLB4_SEQ_SUB_EN
    input  logic             sub,
    output logic             ovf,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    localparam int NIB   = WIDTH / 4;
    localparam int CNT_W = $clog2(NIB);
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIB - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Result of one pass through the 4-bit lookahead slice.
    typedef struct packed {
        logic       co;   // carry out of bit 3
        logic [3:1] c;    // internal carries into bits 1..3
        logic [3:0] sum;
    } slice_t;

    // ------------------------------------------------------------------------
    // clb4: 4-bit carry-lookahead slice. All carries come straight from
    // generate/propagate terms, so none of them ripples through the others.
    // ------------------------------------------------------------------------
    function automatic slice_t clb4(
        input logic [3:0] x,
        input logic [3:0] y,
        input logic       cin
    );
        logic [3:0] p;
        logic [3:0] g;
        slice_t     r;
        p = x ^ y;
        g = x & y;
        r.c[1] = g[0]
               | (p[0] & cin);
        r.c[2] = g[1]
               | (p[1] & g[0])
               | (p[1] & p[0] & cin);
        r.c[3] = g[2]
               | (p[2] & g[1])
               | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & cin);
        r.co   = g[3]
               | (p[3] & g[2])
               | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & cin);
        r.sum  = p ^ {r.c[3], r.c[2], r.c[1], cin};
        return r;
    endfunction

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    state_e           state_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] s_q;
    logic             co_q;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;     // already inverted when subtracting
`ifdef CLB4_SEQ_SUB_EN
    logic             ovf_q;
`endif

    // ------------------------------------------------------------------------
    // Operand capture values.
    // For subtraction, B is inverted and the initial carry is forced to 1
    // here. The slice therefore only ever adds.
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] b_d;
    logic             carry_init_d;
`ifdef CLB4_SEQ_SUB_EN
    assign b_d          = sub ? ~b : b;
    assign carry_init_d = sub | ci;
`else
    assign b_d          = b;
    assign carry_init_d = ci;
`endif

    // A new operation can start only from IDLE or DONE. A start during BUSY
    // is ignored.
    logic accept;
    assign accept = start && (state_q != ST_BUSY);

    // Current nibble: bit offset 4*cnt. The slice sees only that nibble of
    // the captured operands plus the running carry.
    logic [CNT_W+1:0] nib_lsb;
    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    slice_t           slice_d;

    assign nib_lsb = {cnt_q, 2'b00};
    assign a_nib   = a_q[nib_lsb +: 4];
    assign b_nib   = b_q[nib_lsb +: 4];
    assign slice_d = clb4(a_nib, b_nib, carry_q);

    // ------------------------------------------------------------------------
    // FSM and datapath. busy/done are registered with the state, so they
    // change on the same edge as the state and never glitch.
    // ------------------------------------------------------------------------
    // NOTE: every register here uses non-blocking assignment. Each right-hand
    // side therefore sees the pre-edge value, regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            s_q     <= '0;
            co_q    <= 1'b0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
`ifdef CLB4_SEQ_SUB_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            // done is a pulse. Only the last-nibble branch below raises it.
            done_q <= 1'b0;

            if (accept) begin
                // Capture the operands. s/co are left alone; they keep the
                // previous result until nibble 0 of this operation is written.
                a_q     <= a;
                b_q     <= b_d;
                carry_q <= carry_init_d;
                cnt_q   <= '0;
                busy_q  <= 1'b1;
                state_q <= ST_BUSY;
            end else begin
                unique case (state_q)
                    ST_BUSY: begin
                        s_q[nib_lsb +: 4] <= slice_d.sum;
                        carry_q           <= slice_d.co;
                        if (cnt_q == LAST_NIB) begin
                            co_q    <= slice_d.co;
`ifdef CLB4_SEQ_SUB_EN
                            // c[3] is the carry into bit WIDTH-1.
                            ovf_q   <= slice_d.c[3] ^ slice_d.co;
`endif
                            cnt_q   <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_IDLE;
                    end
                    ST_IDLE: begin
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign busy = busy_q;
    assign done = done_q;
    assign s    = s_q;
    assign co   = co_q;
`ifdef CLB4_SEQ_SUB_EN
    assign ovf  = ovf_q;
`endif

endmodule
